// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART auto-baud controller.
//   state_t     : measurement FSM states
//   SYNC_EDGES  : falling edges in a 0x55 sync frame used for one measurement
//   ROUND_SHIFT : log2(8 bit times * 16 oversampling)
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_IDLE  = 3'd1,
    WAIT_START = 3'd2,
    MEASURE    = 3'd3,
    CALC       = 3'd4
  } state_t;

  localparam int SYNC_EDGES  = 5;
  localparam int ROUND_SHIFT = 7;

endpackage

// File: rtl/rx_sync_filt.sv
// -----------------------------------------------------------------------------
// rx_sync_filt
// Brings the raw rx pin into the clk domain and produces a falling-edge strobe.
// Optional macro UART_AUTOBAUD_FILTER_EN inserts a registered 3-tap majority
// filter after the synchronizer; every edge is then delayed by exactly two
// more cycles, so edge-to-edge spacing is preserved.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset (all flops reset to line idle, 1)
//   rx   : raw asynchronous serial input
//   rx_s : synchronized (and, with the macro, filtered) line level
//   fall : one-cycle strobe on a 1->0 transition of rx_s
// -----------------------------------------------------------------------------
module rx_sync_filt (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic rx_s_d;

  // stage: two-flop synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx;
      sync_p1 <= sync_p0;
    end
  end

`ifdef UART_AUTOBAUD_FILTER_EN
  logic hist_p2;
  logic hist_p3;
  logic filt_p3;

  // stage: majority vote over three consecutive samples, registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_p2 <= 1'b1;
      hist_p3 <= 1'b1;
      filt_p3 <= 1'b1;
    end else begin
      hist_p2 <= sync_p1;
      hist_p3 <= hist_p2;
      filt_p3 <= (sync_p1 & hist_p2) | (sync_p1 & hist_p3) | (hist_p2 & hist_p3);
    end
  end

  assign rx_s = filt_p3;
`else
  assign rx_s = sync_p1;
`endif

  // stage: one-cycle delay for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s_d <= 1'b1;
    end else begin
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// -----------------------------------------------------------------------------
// uart_autobaud_ctrl
// Measures a 0x55 sync character on rx and loads the matching divisor into the
// baud rate generator. Falls #1..#5 of 0x55 span 8 bit times, so
// dvsr = round(total / 128) - 1. A failed measurement pulses err and leaves
// the current divisor untouched.
// Optional macro: UART_AUTOBAUD_FILTER_EN (glitch filter inside rx_sync_filt).
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   rx       : raw serial line, idle high
//   arm      : one-cycle request to (re)start a measurement
//   dvsr     : divisor to the baud rate generator
//   dvsr_upd : one-cycle pulse when dvsr is loaded
//   busy     : FSM not in IDLE
//   locked   : last measurement succeeded
//   err      : one-cycle pulse on a failed measurement
// -----------------------------------------------------------------------------
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int                DVSR_W   = 11,
  parameter int                CNT_W    = 19,
  parameter logic [DVSR_W-1:0] DVSR_RST = 11'd650,
  parameter int                MIN_DVSR = 3,
  parameter int                IDLE_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              arm,
  output logic [DVSR_W-1:0] dvsr,
  output logic              dvsr_upd,
  output logic              busy,
  output logic              locked,
  output logic              err
);

  localparam int               IDLE_W    = $clog2(IDLE_CYC) + 1;
  localparam int               SUM_W     = CNT_W + 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
  localparam logic [2:0]       EDGE_LAST = 3'(SYNC_EDGES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] Q_MIN     = CNT_W'(MIN_DVSR + 1);
  localparam logic [CNT_W-1:0] Q_MAX     = CNT_W'(2 ** DVSR_W);
  localparam logic [SUM_W-1:0] RND       = SUM_W'(2 ** (ROUND_SHIFT - 1));

  // Round-to-nearest divide by 128. One extra bit on the sum keeps a count
  // near CNT_MAX from wrapping into a small, falsely acceptable quotient.
  function automatic logic [CNT_W-1:0] round_q(input logic [CNT_W-1:0] t);
    round_q = CNT_W'(({1'b0, t} + RND) >> ROUND_SHIFT);
  endfunction

  logic rx_s;
  logic fall;

  rx_sync_filt u_rx_sync_filt (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  state_t            state;
  state_t            state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  total;
  logic [2:0]        edge_cnt;

  logic [CNT_W-1:0]  q;
  logic              q_ok;
  logic              last_fall;
  logic              accept;
  logic              reject;
  logic              timeout;

  assign q    = round_q(total);
  assign q_ok = (q >= Q_MIN) && (q <= Q_MAX);
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    last_fall = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    timeout   = 1'b0;
    // arm wins over anything else happening in the same cycle
    if (arm) begin
      state_nxt = WAIT_IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        WAIT_IDLE: begin
          if (rx_s && (idle_cnt == IDLE_LAST)) state_nxt = WAIT_START;
        end
        WAIT_START: begin
          if (fall) state_nxt = MEASURE;
        end
        MEASURE: begin
          if (fall && (edge_cnt == EDGE_LAST)) begin
            state_nxt = CALC;
            last_fall = 1'b1;
          end else if (cnt == CNT_MAX) begin
            state_nxt = IDLE;
            timeout   = 1'b1;
          end
        end
        CALC: begin
          state_nxt = IDLE;
          if (q_ok) accept = 1'b1;
          else      reject = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // stage: measurement counters and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      cnt      <= '0;
      edge_cnt <= '0;
      total    <= '0;
      dvsr     <= DVSR_RST;
      dvsr_upd <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      dvsr_upd <= accept;
      err      <= reject | timeout;
      if (accept) begin
        dvsr   <= DVSR_W'(q - CNT_W'(1));
        locked <= 1'b1;
      end
      if (arm) begin
        locked   <= 1'b0;
        idle_cnt <= '0;
      end else begin
        case (state)
          WAIT_IDLE: idle_cnt <= rx_s ? idle_cnt + IDLE_W'(1) : '0;
          WAIT_START: begin
            if (fall) begin
              cnt      <= CNT_W'(1);
              edge_cnt <= '0;
            end
          end
          MEASURE: begin
            cnt <= cnt + CNT_W'(1);
            if (fall) edge_cnt <= edge_cnt + 3'd1;
            if (last_fall) total <= cnt;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
